// File: rtl/b08_sched_pkg.sv
// rtl/b08_sched_pkg.sv - shared types and constants for the b08 scan sequencer
package b08_sched_pkg;

    localparam int W_IN  = 8;
    localparam int W_OUT = 4;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [W_IN-1:0]  pat;
        logic [W_IN-1:0]  mask;
        logic [W_OUT-1:0] out;
    } entry_t;

    // Reset entry only matches an all-zero word and contributes no code bits.
    localparam entry_t ENTRY_RST = '{pat: '0, mask: '1, out: '0};

    // Masked compare: only bits with mask=1 have to agree with the pattern.
    function automatic logic entry_match(input entry_t e, input logic [W_IN-1:0] w);
        return ((w ^ e.pat) & e.mask) == '0;
    endfunction

endpackage

// File: rtl/b08_scan_sched_if.sv
// rtl/b08_scan_sched_if.sv - client, config and response bus of the scan sequencer
interface b08_scan_sched_if #(
    parameter int N_REQ = 4
);
    import b08_sched_pkg::*;

    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*W_IN-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;

    logic                  cfg_we;
    logic [AW-1:0]         cfg_addr;
    logic [W_IN-1:0]       cfg_pat;
    logic [W_IN-1:0]       cfg_mask;
    logic [W_OUT-1:0]      cfg_out;
    logic                  cfg_ready;

    logic                  rsp_valid;
    logic [IW-1:0]         rsp_id;
    logic [W_OUT-1:0]      rsp_data;
    logic                  rsp_hit;
    logic                  rsp_ready;

    logic                  busy;

    modport master (
        output req_valid, req_data, cfg_we, cfg_addr, cfg_pat, cfg_mask, cfg_out, rsp_ready,
        input  req_ready, cfg_ready, rsp_valid, rsp_id, rsp_data, rsp_hit, busy
    );

    modport slave (
        input  req_valid, req_data, cfg_we, cfg_addr, cfg_pat, cfg_mask, cfg_out, rsp_ready,
        output req_ready, cfg_ready, rsp_valid, rsp_id, rsp_data, rsp_hit, busy
    );

endinterface

// File: rtl/b08_rr_arb.sv
// rtl/b08_rr_arb.sv - round-robin arbiter searching upward from ptr with wrap
module b08_rr_arb #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_any
);

    logic [IW-1:0] cand;

    // First requester at or above ptr (wrapping) wins; nothing is granted when disabled.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IW'((int'(ptr) + i) % N_REQ);
            if (en && !gnt_any && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/b08_scan_sched.sv
// rtl/b08_scan_sched.sv - arbitrated front end and table sequencer of the b08 scan engine
module b08_scan_sched
    import b08_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    b08_scan_sched_if.slave  bus
);

    localparam int IW = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    id_q, id_d;
    logic [AW-1:0]    mar_q, mar_d;
    logic [W_IN-1:0]  in_q, in_d;
    logic [W_OUT-1:0] acc_q, acc_d;
    logic             hit_q, hit_d;
    entry_t           table_q [DEPTH];
    entry_t           table_d [DEPTH];

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             arb_en;
    entry_t           cur;

    // Grants only while idle; reset forces req_ready low immediately.
    assign arb_en = (state_q == IDLE) && !RESET;
    assign cur    = table_q[mar_q];

    b08_rr_arb #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign bus.req_ready = gnt;
    assign bus.cfg_ready = (state_q == IDLE) && !RESET;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = acc_q;
    assign bus.rsp_hit   = hit_q;
    assign bus.busy      = (state_q != IDLE);

    // Next state: accept and latch in IDLE, one table entry per SCAN cycle, hold in RESP.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        mar_d   = mar_q;
        in_d    = in_q;
        acc_d   = acc_q;
        hit_d   = hit_q;
        table_d = table_q;
        case (state_q)
            IDLE: begin
                if (bus.cfg_we) begin
                    table_d[bus.cfg_addr] = '{pat: bus.cfg_pat, mask: bus.cfg_mask, out: bus.cfg_out};
                end
                if (gnt_any) begin
                    in_d    = bus.req_data[int'(gnt_idx)*W_IN +: W_IN];
                    id_d    = gnt_idx;
                    mar_d   = '0;
                    acc_d   = '0;
                    hit_d   = 1'b0;
                    ptr_d   = (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + IW'(1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (entry_match(cur, in_q)) begin
                    acc_d = acc_q | cur.out;
                    hit_d = 1'b1;
                end
                mar_d = mar_q + AW'(1);
                if (mar_q == AW'(DEPTH-1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and table registers; reset discards any transaction in flight.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            mar_q   <= '0;
            in_q    <= '0;
            acc_q   <= '0;
            hit_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= ENTRY_RST;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            mar_q   <= mar_d;
            in_q    <= in_d;
            acc_q   <= acc_d;
            hit_q   <= hit_d;
            table_q <= table_d;
        end
    end

endmodule
